// File: rtl/vin_spiadc_responder_if.sv
// Command/response stream between a modular-ADC sequencer (master) and the SPI ADC responder (slave).
interface vin_spiadc_responder_if;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        response_startofpacket;
    logic        response_endofpacket;

    modport master (
        output command_valid, command_channel, command_startofpacket, command_endofpacket,
        input  command_ready,
        input  response_valid, response_channel, response_data,
        input  response_startofpacket, response_endofpacket
    );

    modport slave (
        input  command_valid, command_channel, command_startofpacket, command_endofpacket,
        output command_ready,
        output response_valid, response_channel, response_data,
        output response_startofpacket, response_endofpacket
    );
endinterface

// File: rtl/vin_spiadc_responder.sv
// Modular-ADC responder backed by an MCP3208-class SPI ADC (mode 0, 19-clock frame).
// Define VIN_SPIADC_DIFF_EN to also accept channels 17..16+NUM_CHANNELS as pseudo-differential.
module vin_spiadc_responder #(
    parameter int unsigned CLK_DIV      = 8,
    parameter int unsigned NUM_CHANNELS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    vin_spiadc_responder_if.slave        stream,
    output logic                         spi_cs,
    output logic                         spi_clk,
    output logic                         spi_mosi,
    input  logic                         spi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        RESPOND
    } state_t;

    state_t      state, state_d;
    logic [7:0]  div_cnt;
    logic        div_done;
    logic        phase;
    logic [4:0]  bit_cnt;
    logic [11:0] shreg;
    logic [4:0]  ch_q;
    logic        sop_q, eop_q, sgl_q;
    logic [2:0]  addr_q;
    logic        accept;
    logic        cmd_se, cmd_diff, cmd_ok;

    assign div_done = (div_cnt == 8'(CLK_DIV - 1));

    assign cmd_se = (stream.command_channel >= 5'd1) &&
                    (stream.command_channel <= 5'(NUM_CHANNELS));
`ifdef VIN_SPIADC_DIFF_EN
    assign cmd_diff = (stream.command_channel >= 5'd17) &&
                      (stream.command_channel <= 5'(16 + NUM_CHANNELS));
`else
    assign cmd_diff = 1'b0;
`endif
    assign cmd_ok = cmd_se || cmd_diff;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d              = state;
        accept               = 1'b0;
        stream.command_ready = 1'b0;
        stream.response_valid = 1'b0;
        spi_cs               = 1'b1;
        spi_clk              = 1'b0;
        spi_mosi             = 1'b0;
        unique case (state)
            IDLE: begin
                stream.command_ready = !reset;
                accept = stream.command_valid && !reset;
                if (accept) state_d = cmd_ok ? CS_SETUP : RESPOND;
            end
            CS_SETUP: begin
                spi_cs = 1'b0;
                if (div_done) state_d = SHIFT;
            end
            SHIFT: begin
                spi_cs  = 1'b0;
                spi_clk = phase;
                // Header bits are indexed by SPI cycle, which only advances on the falling half.
                case (bit_cnt)
                    5'd1:    spi_mosi = 1'b1;
                    5'd2:    spi_mosi = sgl_q;
                    5'd3:    spi_mosi = addr_q[2];
                    5'd4:    spi_mosi = addr_q[1];
                    5'd5:    spi_mosi = addr_q[0];
                    default: spi_mosi = 1'b0;
                endcase
                if (div_done && phase && (bit_cnt == 5'd19)) state_d = CS_HOLD;
            end
            CS_HOLD: begin
                if (div_done) state_d = RESPOND;
            end
            RESPOND: begin
                stream.response_valid = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt                       <= '0;
            phase                         <= 1'b0;
            bit_cnt                       <= '0;
            shreg                         <= '0;
            ch_q                          <= '0;
            sop_q                         <= 1'b0;
            eop_q                         <= 1'b0;
            sgl_q                         <= 1'b1;
            addr_q                        <= '0;
            stream.response_channel       <= '0;
            stream.response_data          <= '0;
            stream.response_startofpacket <= 1'b0;
            stream.response_endofpacket   <= 1'b0;
        end else begin
            if (div_done || (state != state_d) || (state == IDLE)) div_cnt <= '0;
            else                                                   div_cnt <= div_cnt + 8'd1;

            if (state == CS_SETUP) begin
                phase   <= 1'b0;
                bit_cnt <= 5'd1;
            end else if ((state == SHIFT) && div_done) begin
                if (!phase) begin
                    phase <= 1'b1;
                    if (bit_cnt >= 5'd8) shreg <= {shreg[10:0], spi_miso};
                end else begin
                    phase   <= 1'b0;
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end

            // Channel 17 and channel 1 share low bits, so one subtract serves both modes.
            if (accept) begin
                ch_q   <= stream.command_channel;
                sop_q  <= stream.command_startofpacket;
                eop_q  <= stream.command_endofpacket;
                sgl_q  <= !cmd_diff;
                addr_q <= stream.command_channel[2:0] - 3'd1;
                shreg  <= '0;
            end

            if ((state_d == RESPOND) && (state != RESPOND)) begin
                if (state == IDLE) begin
                    stream.response_channel       <= stream.command_channel;
                    stream.response_data          <= '0;
                    stream.response_startofpacket <= stream.command_startofpacket;
                    stream.response_endofpacket   <= stream.command_endofpacket;
                end else begin
                    stream.response_channel       <= ch_q;
                    stream.response_data          <= shreg;
                    stream.response_startofpacket <= sop_q;
                    stream.response_endofpacket   <= eop_q;
                end
            end
        end
    end

endmodule

// File: doc/vin_spiadc_responder.md
VIN_SPIADC_RESPONDER -- requirements
Module: vin_spiadc_responder

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8, giving the SPI half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have parameter NUM_CHANNELS, default 8, giving the number of single-ended ADC inputs; legal range 1..8.
REQ-003 SHALL have ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- command_valid  input  1  command request.
- command_channel  input  5  requested channel.
- command_startofpacket  input  1  echoed to the response.
- command_endofpacket  input  1  echoed to the response.
- command_ready  output  1  block can accept a command.
- response_valid  output  1  single-cycle result strobe.
- response_channel  output  5  channel of the result.
- response_data  output  12  conversion result.
- response_startofpacket  output  1  echoed SOP.
- response_endofpacket  output  1  echoed EOP.
- spi_cs  output  1  ADC chip select, active low.
- spi_clk  output  1  SPI clock.
- spi_mosi  output  1  data to the ADC.
- spi_miso  input  1  data from the ADC.

Function
REQ-004 SHALL implement the responder side of the modular-ADC command/response stream, backed by an external MCP3208-class SPI ADC.
REQ-005 SHALL use states IDLE, CS_SETUP, SHIFT, CS_HOLD, RESPOND.
REQ-006 SHALL drive command_ready high only in IDLE.
REQ-007 SHALL accept a command when command_valid and command_ready are both high; command_valid is ignored in all other states.
REQ-008 SHALL latch channel, SOP and EOP on acceptance; the latched values are stable until the next acceptance.
REQ-009 SHALL treat command_channel values 1..NUM_CHANNELS as valid, mapping them to ADC input (channel-1), single-ended.
REQ-010 On acceptance of an invalid channel, SHALL skip SPI, enter RESPOND on the next cycle, and return response_data = 0 with the echoed channel, SOP and EOP.
REQ-011 On acceptance of a valid channel, SHALL go to CS_SETUP: spi_cs low for CLK_DIV cycles with spi_clk low.
REQ-012 SHIFT SHALL produce exactly 19 SPI mode-0 cycles:
- spi_clk low for CLK_DIV cycles, then high for CLK_DIV cycles;
- spi_mosi changes only while spi_clk is low.
REQ-013 spi_mosi SHALL carry, on SPI cycles 1..5: start=1, SGL=1, D2, D1, D0; it SHALL be 0 on cycles 6..19.
REQ-014 SHALL sample spi_miso on the rising spi_clk edge of cycles 8..19, MSB first, into response_data[11:0].
REQ-015 After cycle 19, CS_HOLD SHALL hold spi_cs high and spi_clk low for CLK_DIV cycles, then enter RESPOND.
REQ-016 In RESPOND, SHALL assert response_valid for exactly one cycle with the data, channel, SOP and EOP, then return to IDLE.
REQ-017 For a valid channel, response_valid SHALL assert exactly 40*CLK_DIV+1 cycles after the acceptance edge.
REQ-018 response_data, response_channel, response_startofpacket and response_endofpacket SHALL hold their values until the next RESPOND.
REQ-019 The stream SHALL have no backpressure; the consumer must take response_valid when it is presented.
REQ-020 command_ready SHALL reassert on the cycle after response_valid, so a command held valid is accepted then.

Reset
REQ-021 While reset is high, the block SHALL be in IDLE with:
- command_ready = 0;
- response_valid = 0, response_data = 0, response_channel = 0, response_startofpacket = 0, response_endofpacket = 0;
- spi_cs = 1, spi_clk = 0, spi_mosi = 0.
REQ-022 command_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-023 Reset asserted mid-transaction SHALL abort the transaction, raise spi_cs on the next edge, and produce no response for the aborted command.

Configuration
REQ-024 When macro VIN_SPIADC_DIFF_EN is defined, command_channel values 17..(16+NUM_CHANNELS) SHALL also be valid, sent with SGL=0 and D2..D0 = channel-17 (pseudo-differential).
REQ-025 When VIN_SPIADC_DIFF_EN is undefined, channels 17..24 SHALL be treated as invalid per REQ-010, and SGL SHALL always be 1.

Verification
REQ-026 Channel 1, SPI slave model returning 0xABC, CLK_DIV=8 -> mosi bits 1,1,0,0,0; response_valid at +321 cycles; data 0xABC; channel 1.
REQ-027 Channel 8 with SOP=1, EOP=0, slave returns 0x001 -> D2..D0 = 111; response data 0x001, channel 8, SOP 1, EOP 0.
REQ-028 Channel 0, then channel 9 -> no spi_cs activity; each response_valid arrives 1 cycle after acceptance with data 0.
REQ-029 command_valid held high continuously for 3 commands -> exactly one acceptance per transaction; spi_cs high at least CLK_DIV cycles between frames.
REQ-030 Reset pulsed at SPI cycle 10 -> spi_cs high the next cycle; no response_valid; command_ready = 1 one cycle after reset deasserts.
REQ-031 With VIN_SPIADC_DIFF_EN, channel 18 -> SGL=0, D2..D0 = 001; without the macro -> immediate response with data 0.
